// File: rtl/fifo_uart_pkg.sv
// Shared UART constants and transmitter state encoding; no logic, no latency.
package fifo_uart_pkg;

  localparam int   UART_DATA_BITS       = 8;
  localparam logic UART_IDLE_LEVEL      = 1'b1;
  localparam int   DEFAULT_CLKS_PER_BIT = 868;
  localparam int   DEFAULT_READ_HOLD    = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_LATCH = 3'd2;
  localparam state_t ST_START = 3'd3;
  localparam state_t ST_DATA  = 3'd4;
  localparam state_t ST_STOP  = 3'd5;

  // States that occupy whole bit periods on the line and need the baud counter.
  function automatic logic is_bit_state(input state_t s);
    return (s == ST_START) || (s == ST_DATA) || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Pulse-mode FIFO read port: master pops with a held read_en, slave returns status and last read data.
interface fifo_uart_tx_if;
  import fifo_uart_pkg::*;

  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_data;
  logic                      fifo_read_en;

  modport master (output fifo_read_en, input fifo_empty, input fifo_data);
  modport slave  (input fifo_read_en, output fifo_empty, output fifo_data);

endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period timer: bit_tick is high in the last cycle of each CLKS_PER_BIT period while run is set.
// clear restarts the period at zero; counter holds when run is low.
module uart_baud_counter
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic bit_tick
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = run && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops one byte from a pulse-mode FIFO and sends it as 8N1 UART; tx goes low READ_HOLD+2 edges after the pop decision.
// All outputs are registered; a new byte starts only from IDLE with enable high and the FIFO non-empty.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int READ_HOLD    = DEFAULT_READ_HOLD
) (
  input  logic                  sys_clock,
  input  logic                  reset,
  input  logic                  enable,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  byte_done
);

  localparam logic [3:0] HOLD_LAST = 4'(READ_HOLD - 1);

  state_t                    state_q, state_d;
  logic [3:0]                hold_q, hold_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      read_en_q, read_en_d;
  logic                      done_q, done_d;
  logic                      bit_tick;
  logic                      baud_clear;

  assign baud_clear = (state_d != state_q);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (sys_clock),
    .rst      (reset),
    .clear    (baud_clear),
    .run      (is_bit_state(state_q)),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo.fifo_empty) begin
          state_d = ST_FETCH;
          hold_d  = '0;
        end
      end
      ST_FETCH: begin
        hold_d = hold_q + 4'd1;
        if (hold_q == HOLD_LAST) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        // read_en has just fallen, so d_out is the popped byte and stays put.
        shift_d = fifo.fifo_data;
        state_d = ST_START;
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level and done pulse are decoded from the current state, so they trail it by one cycle.
  always_comb begin
    read_en_d = (state_d == ST_FETCH);
    done_d    = (state_q == ST_STOP) && bit_tick;
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= UART_IDLE_LEVEL;
      read_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      read_en_q <= read_en_d;
      done_q    <= done_d;
    end
  end

  assign tx                = tx_q;
  assign byte_done         = done_q;
  assign busy              = (state_q != ST_IDLE);
  assign fifo.fifo_read_en = read_en_q;

endmodule
